// File: rtl/ws2812_frame_scheduler.sv
// Two-source round-robin frame scheduler for a WS2812 strip: grants one source
// a whole 3*LEDS-byte frame, then holds the line idle for the latch gap.
module ws2812_frame_scheduler #(
  parameter int LEDS         = 32,
  parameter int LATCH_CYCLES = 1200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src0_req,
  input  logic       src1_req,
  input  logic [7:0] src0_color,
  input  logic [7:0] src1_color,
  output logic       src0_grant,
  output logic       src1_grant,
  output logic       src0_data_request,
  output logic       src1_data_request,
  output logic       tx_trigger,
  input  logic       tx_data_request,
  output logic [7:0] color_out,
  output logic       frame_done
);

  localparam int NBYTES = 3 * LEDS;
  localparam int BW     = $clog2(NBYTES);
  localparam int LW     = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]   latch_cnt_q, latch_cnt_d;
  logic            grant0_q, grant0_d;
  logic            grant1_q, grant1_d;
  logic            last_q, last_d;       // 1: source 1 owned the previous frame
  logic            frame_done_q, frame_done_d;
  logic            pick1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      latch_cnt_q  <= '0;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      last_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      latch_cnt_q  <= latch_cnt_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Source 1 wins if it is the only requester, or on contention when source 0 went last.
  assign pick1 = src1_req & (~src0_req | ~last_q);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    latch_cnt_d  = latch_cnt_q;
    grant0_d     = grant0_q;
    grant1_d     = grant1_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (src0_req | src1_req) begin
          grant0_d   = ~pick1;
          grant1_d   = pick1;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_data_request) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d      = LATCH;
            grant0_d     = 1'b0;
            grant1_d     = 1'b0;
            last_d       = grant1_q;
            latch_cnt_d  = LATCH_LOAD;
            frame_done_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      LATCH: begin
        if (latch_cnt_q == '0) state_d = IDLE;
        else                   latch_cnt_d = latch_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_trigger        = (state_q == SEND);
  assign src0_data_request = tx_data_request & tx_trigger & grant0_q & ~rst;
  assign src1_data_request = tx_data_request & tx_trigger & grant1_q & ~rst;
  assign src0_grant        = grant0_q;
  assign src1_grant        = grant1_q;
  assign frame_done        = frame_done_q;
  assign color_out         = grant0_q ? src0_color : (grant1_q ? src1_color : 8'h00);

endmodule
